// File: rtl/branch_unit_if.sv
// branch_unit_if: core-side bundle for the per-thread branch unit.
// master = core/decoder side, slave = branch_unit.
interface branch_unit_if #(
  parameter int PC_BITS    = 8,
  parameter int COUNT_BITS = 16
);
  logic                  enable;
  logic [2:0]            core_state;
  logic [2:0]            decoded_nzp;
  logic [7:0]            decoded_immediate;
  logic                  decoded_nzp_write_enable;
  logic                  decoded_pc_mux;
  logic                  decoded_call;
  logic                  decoded_ret;
  logic [7:0]            alu_out;
  logic [PC_BITS-1:0]    current_pc;
  logic [PC_BITS-1:0]    next_pc;
  logic [2:0]            nzp;
  logic                  branch_taken;
  logic [COUNT_BITS-1:0] taken_count;
  logic                  stack_overflow;
  logic                  stack_underflow;

  modport master (
    output enable, core_state, decoded_nzp,
    output decoded_immediate,
    output decoded_nzp_write_enable,
    output decoded_pc_mux, decoded_call,
    output decoded_ret, alu_out, current_pc,
    input  next_pc, nzp, branch_taken,
    input  taken_count, stack_overflow,
    input  stack_underflow
  );

  modport slave (
    input  enable, core_state, decoded_nzp,
    input  decoded_immediate,
    input  decoded_nzp_write_enable,
    input  decoded_pc_mux, decoded_call,
    input  decoded_ret, alu_out, current_pc,
    output next_pc, nzp, branch_taken,
    output taken_count, stack_overflow,
    output stack_underflow
  );
endinterface

// File: rtl/branch_unit.sv
// branch_unit: NZP latch, BRnzp resolve, next_pc register, taken counter.
// Optional call/return stack: define BRANCH_UNIT_CALL_STACK_EN.
module branch_unit #(
  parameter int PC_BITS     = 8,
  parameter int COUNT_BITS  = 16,
  parameter int STACK_DEPTH = 4
) (
  input logic          clk,
  input logic          reset,
  branch_unit_if.slave bus
);
  localparam logic [2:0] ST_EXECUTE = 3'b101;
  localparam logic [2:0] ST_UPDATE  = 3'b110;

  logic [PC_BITS-1:0]    next_pc_q, next_pc_d;
  logic [2:0]            nzp_q, nzp_d;
  logic                  taken_q, taken_d;
  logic [COUNT_BITS-1:0] count_q, count_d;
  logic                  done_q, done_d;

  logic               in_exec;
  logic               is_exec;
  logic               br_hit;
  logic [PC_BITS-1:0] seq_pc;
  logic [PC_BITS-1:0] imm_pc;
  logic               stk_sel;
  logic               stk_taken;
  logic [PC_BITS-1:0] stk_pc;

  // done_q limits resolution to the first edge of an EXECUTE phase
  assign in_exec = bus.enable
                && bus.core_state == ST_EXECUTE;
  assign is_exec = in_exec && !done_q;
  assign seq_pc  = bus.current_pc + PC_BITS'(1);
  assign imm_pc  = PC_BITS'(bus.decoded_immediate);
  assign br_hit  = bus.decoded_pc_mux
                && |(nzp_q & bus.decoded_nzp);

`ifdef BRANCH_UNIT_CALL_STACK_EN
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = (STACK_DEPTH > 1)
                     ? $clog2(STACK_DEPTH) : 1;

  logic [SPW-1:0]     sp_q, sp_d;
  logic [PC_BITS-1:0] stack_q [STACK_DEPTH];
  logic [PC_BITS-1:0] stack_d [STACK_DEPTH];
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               full, empty;
  logic [IW-1:0]      push_idx, pop_idx;
  logic               unused_bits;

  assign full     = sp_q == SPW'(STACK_DEPTH);
  assign empty    = sp_q == '0;
  assign push_idx = IW'(sp_q);
  assign pop_idx  = IW'(sp_q - SPW'(1));

  assign unused_bits = ^bus.alu_out[7:3];

  // RET beats CALL; overflowing CALL still jumps, empty RET falls through
  always_comb begin
    sp_d      = sp_q;
    stack_d   = stack_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    stk_sel   = 1'b0;
    stk_taken = 1'b0;
    stk_pc    = seq_pc;
    if (is_exec) begin
      if (bus.decoded_ret) begin
        stk_sel = 1'b1;
        if (empty) begin
          unf_d = 1'b1;
        end else begin
          sp_d      = sp_q - SPW'(1);
          stk_pc    = stack_q[pop_idx];
          stk_taken = 1'b1;
        end
      end else if (bus.decoded_call) begin
        stk_sel   = 1'b1;
        stk_taken = 1'b1;
        stk_pc    = imm_pc;
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          stack_d[push_idx] = seq_pc;
          sp_d = sp_q + SPW'(1);
        end
      end
    end
  end

  // stack pointer, entries and sticky error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++)
        stack_q[i] <= '0;
    end else begin
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      stack_q <= stack_d;
    end
  end

  assign bus.stack_overflow  = ovf_q;
  assign bus.stack_underflow = unf_q;
`else
  logic unused_bits;

  assign unused_bits = ^{bus.alu_out[7:3],
                         bus.decoded_call,
                         bus.decoded_ret};

  assign stk_sel   = 1'b0;
  assign stk_taken = 1'b0;
  assign stk_pc    = seq_pc;

  assign bus.stack_overflow  = 1'b0;
  assign bus.stack_underflow = 1'b0;
`endif

  // resolve next_pc in EXECUTE, latch NZP in UPDATE
  always_comb begin
    next_pc_d = next_pc_q;
    nzp_d     = nzp_q;
    taken_d   = taken_q;
    count_d   = count_q;
    done_d    = done_q;
    if (bus.core_state != ST_EXECUTE)
      done_d = 1'b0;
    else if (bus.enable)
      done_d = 1'b1;
    if (is_exec) begin
      if (stk_sel) begin
        next_pc_d = stk_pc;
        taken_d   = stk_taken;
      end else if (br_hit) begin
        next_pc_d = imm_pc;
        taken_d   = 1'b1;
      end else begin
        next_pc_d = seq_pc;
        taken_d   = 1'b0;
      end
      if (taken_d && count_q != '1)
        count_d = count_q + COUNT_BITS'(1);
    end
    if (bus.enable
        && bus.core_state == ST_UPDATE
        && bus.decoded_nzp_write_enable)
      nzp_d = bus.alu_out[2:0];
  end

  // architectural registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      next_pc_q <= '0;
      nzp_q     <= '0;
      taken_q   <= 1'b0;
      count_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      next_pc_q <= next_pc_d;
      nzp_q     <= nzp_d;
      taken_q   <= taken_d;
      count_q   <= count_d;
      done_q    <= done_d;
    end
  end

  assign bus.next_pc      = next_pc_q;
  assign bus.nzp          = nzp_q;
  assign bus.branch_taken = taken_q;
  assign bus.taken_count  = count_q;
endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: directed tests for branch_unit.
// Second instance with COUNT_BITS=2 covers counter saturation.
module tb_branch_unit;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  branch_unit_if #(.PC_BITS(8), .COUNT_BITS(16)) bi ();
  branch_unit_if #(.PC_BITS(8), .COUNT_BITS(2))  bi2 ();

  branch_unit #(
    .PC_BITS(8), .COUNT_BITS(16), .STACK_DEPTH(4)
  ) dut (
    .clk(clk), .reset(rst_n), .bus(bi.slave)
  );

  branch_unit #(
    .PC_BITS(8), .COUNT_BITS(2), .STACK_DEPTH(4)
  ) dut2 (
    .clk(clk), .reset(rst_n), .bus(bi2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bi.enable = 1'b1;
    bi.core_state = 3'b000;
    bi.decoded_nzp = 3'b000;
    bi.decoded_immediate = 8'h00;
    bi.decoded_nzp_write_enable = 1'b0;
    bi.decoded_pc_mux = 1'b0;
    bi.decoded_call = 1'b0;
    bi.decoded_ret = 1'b0;
    bi.alu_out = 8'h00;
    bi.current_pc = 8'h00;
  endtask

  task automatic do_exec(
    input logic en, input logic [7:0] pc,
    input logic [7:0] imm, input logic [2:0] m,
    input logic br, input logic cl, input logic rt
  );
    @(negedge clk);
    bi.enable = en;
    bi.core_state = 3'b101;
    bi.current_pc = pc;
    bi.decoded_immediate = imm;
    bi.decoded_nzp = m;
    bi.decoded_pc_mux = br;
    bi.decoded_call = cl;
    bi.decoded_ret = rt;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic do_update(
    input logic en, input logic we, input logic [7:0] alu
  );
    @(negedge clk);
    bi.enable = en;
    bi.core_state = 3'b110;
    bi.decoded_nzp_write_enable = we;
    bi.alu_out = alu;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    bi2.enable = 1'b0;
    bi2.core_state = 3'b000;
    bi2.decoded_nzp = 3'b000;
    bi2.decoded_immediate = 8'h00;
    bi2.decoded_nzp_write_enable = 1'b0;
    bi2.decoded_pc_mux = 1'b0;
    bi2.decoded_call = 1'b0;
    bi2.decoded_ret = 1'b0;
    bi2.alu_out = 8'h00;
    bi2.current_pc = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if (bi.next_pc !== 8'h00 || bi.nzp !== 3'b000
        || bi.branch_taken !== 1'b0
        || bi.taken_count !== 16'h0
        || bi.stack_overflow !== 1'b0
        || bi.stack_underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state pc=%h nzp=%b tk=%b cnt=%0d",
               bi.next_pc, bi.nzp, bi.branch_taken,
               bi.taken_count);
    end
    rst_n = 1'b1;
    do_update(1'b1, 1'b1, 8'h07);
    do_exec(1'b1, 8'h10, 8'h3C, 3'b111, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bi.next_pc !== 8'h3C || bi.taken_count !== 16'd1) begin
      errors++;
      $display("FAIL pre_reset pc=%h cnt=%0d want 3c 1",
               bi.next_pc, bi.taken_count);
    end
    @(negedge clk);
    bi.core_state = 3'b101;
    bi.decoded_pc_mux = 1'b1;
    bi.decoded_nzp = 3'b111;
    bi.decoded_immediate = 8'h44;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bi.next_pc !== 8'h00 || bi.nzp !== 3'b000
        || bi.taken_count !== 16'h0
        || bi.branch_taken !== 1'b0) begin
      errors++;
      $display("FAIL async_reset pc=%h nzp=%b cnt=%0d tk=%b",
               bi.next_pc, bi.nzp, bi.taken_count,
               bi.branch_taken);
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_branch_taken();
    do_update(1'b1, 1'b1, 8'h04);
    checks++;
    if (bi.nzp !== 3'b100) begin
      errors++;
      $display("FAIL cmp_nzp got %b want 100", bi.nzp);
    end
    do_exec(1'b1, 8'h05, 8'h20, 3'b100, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bi.next_pc !== 8'h20 || bi.branch_taken !== 1'b1
        || bi.taken_count !== 16'd1) begin
      errors++;
      $display("FAIL brn_taken pc=%h tk=%b cnt=%0d want 20 1 1",
               bi.next_pc, bi.branch_taken, bi.taken_count);
    end
  endtask

  task automatic test_branch_not_taken();
    do_update(1'b1, 1'b1, 8'h02);
    checks++;
    if (bi.nzp !== 3'b010) begin
      errors++;
      $display("FAIL cmp_zero got %b want 010", bi.nzp);
    end
    do_exec(1'b1, 8'hFF, 8'h40, 3'b101, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bi.next_pc !== 8'h00 || bi.branch_taken !== 1'b0
        || bi.taken_count !== 16'd1) begin
      errors++;
      $display("FAIL brnp_wrap pc=%h tk=%b cnt=%0d want 00 0 1",
               bi.next_pc, bi.branch_taken, bi.taken_count);
    end
  endtask

  task automatic test_hold();
    do_update(1'b1, 1'b0, 8'h01);
    checks++;
    if (bi.nzp !== 3'b010) begin
      errors++;
      $display("FAIL nzp_hold got %b want 010", bi.nzp);
    end
    do_update(1'b0, 1'b1, 8'h01);
    checks++;
    if (bi.nzp !== 3'b010) begin
      errors++;
      $display("FAIL upd_disabled got %b want 010", bi.nzp);
    end
    do_exec(1'b0, 8'h30, 8'h55, 3'b010, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bi.next_pc !== 8'h00 || bi.branch_taken !== 1'b0
        || bi.taken_count !== 16'd1) begin
      errors++;
      $display("FAIL exec_disabled pc=%h tk=%b cnt=%0d",
               bi.next_pc, bi.branch_taken, bi.taken_count);
    end
    @(negedge clk);
    bi.core_state = 3'b010;
    bi.decoded_pc_mux = 1'b1;
    bi.decoded_nzp = 3'b010;
    bi.decoded_immediate = 8'h55;
    bi.decoded_nzp_write_enable = 1'b1;
    bi.alu_out = 8'h04;
    @(negedge clk);
    clear_inputs();
    checks++;
    if (bi.next_pc !== 8'h00 || bi.nzp !== 3'b010
        || bi.taken_count !== 16'd1) begin
      errors++;
      $display("FAIL decode_hold pc=%h nzp=%b cnt=%0d",
               bi.next_pc, bi.nzp, bi.taken_count);
    end
    do_exec(1'b1, 8'h30, 8'h55, 3'b000, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bi.next_pc !== 8'h31 || bi.branch_taken !== 1'b0) begin
      errors++;
      $display("FAIL mask_000 pc=%h tk=%b want 31 0",
               bi.next_pc, bi.branch_taken);
    end
    do_update(1'b1, 1'b1, 8'hFB);
    checks++;
    if (bi.nzp !== 3'b011) begin
      errors++;
      $display("FAIL nzp_verbatim got %b want 011", bi.nzp);
    end
    do_update(1'b1, 1'b1, 8'hFA);
    checks++;
    if (bi.nzp !== 3'b010) begin
      errors++;
      $display("FAIL nzp_hi_ignored got %b want 010", bi.nzp);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt [4];
    exp_cnt[0] = 2'd1;
    exp_cnt[1] = 2'd2;
    exp_cnt[2] = 2'd3;
    exp_cnt[3] = 2'd3;
    @(negedge clk);
    bi2.enable = 1'b1;
    bi2.core_state = 3'b110;
    bi2.decoded_nzp_write_enable = 1'b1;
    bi2.alu_out = 8'h01;
    @(negedge clk);
    bi2.decoded_nzp_write_enable = 1'b0;
    bi2.core_state = 3'b000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bi2.core_state = 3'b101;
      bi2.decoded_pc_mux = 1'b1;
      bi2.decoded_nzp = 3'b001;
      bi2.decoded_immediate = 8'h60 + 8'(i);
      bi2.current_pc = 8'h08;
      @(negedge clk);
      bi2.core_state = 3'b000;
      checks++;
      if (bi2.taken_count !== exp_cnt[i]
          || bi2.next_pc !== 8'h60 + 8'(i)) begin
        errors++;
        $display("FAIL sat_cnt%0d cnt=%0d pc=%h want %0d",
                 i, bi2.taken_count, bi2.next_pc, exp_cnt[i]);
      end
    end
  endtask

  task automatic test_stack();
`ifdef BRANCH_UNIT_CALL_STACK_EN
    logic [7:0] ret_pc [4];
    ret_pc[0] = 8'h14;
    ret_pc[1] = 8'h13;
    ret_pc[2] = 8'h12;
    ret_pc[3] = 8'h11;
    for (int i = 0; i < 5; i++) begin
      do_exec(1'b1, 8'h10 + 8'(i), 8'h80 + 8'(i),
              3'b000, 1'b0, 1'b1, 1'b0);
      checks++;
      if (bi.next_pc !== 8'h80 + 8'(i)
          || bi.branch_taken !== 1'b1
          || bi.stack_overflow !== (i == 4)
          || bi.taken_count !== 16'(2 + i)) begin
        errors++;
        $display("FAIL call%0d pc=%h tk=%b ovf=%b cnt=%0d",
                 i, bi.next_pc, bi.branch_taken,
                 bi.stack_overflow, bi.taken_count);
      end
    end
    for (int i = 0; i < 4; i++) begin
      do_exec(1'b1, 8'h90, 8'h00, 3'b000, 1'b0, 1'b0, 1'b1);
      checks++;
      if (bi.next_pc !== ret_pc[i]
          || bi.branch_taken !== 1'b1
          || bi.stack_underflow !== 1'b0
          || bi.taken_count !== 16'(7 + i)) begin
        errors++;
        $display("FAIL ret%0d pc=%h want %h tk=%b cnt=%0d",
                 i, bi.next_pc, ret_pc[i],
                 bi.branch_taken, bi.taken_count);
      end
    end
    do_exec(1'b1, 8'h90, 8'h00, 3'b000, 1'b0, 1'b0, 1'b1);
    checks++;
    if (bi.next_pc !== 8'h91 || bi.branch_taken !== 1'b0
        || bi.stack_underflow !== 1'b1
        || bi.stack_overflow !== 1'b1
        || bi.taken_count !== 16'd10) begin
      errors++;
      $display("FAIL ret_empty pc=%h tk=%b unf=%b cnt=%0d",
               bi.next_pc, bi.branch_taken,
               bi.stack_underflow, bi.taken_count);
    end
`else
    do_exec(1'b1, 8'h10, 8'h80, 3'b000, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bi.next_pc !== 8'h11 || bi.branch_taken !== 1'b0
        || bi.stack_overflow !== 1'b0
        || bi.stack_underflow !== 1'b0
        || bi.taken_count !== 16'd1) begin
      errors++;
      $display("FAIL call_nostack pc=%h tk=%b cnt=%0d",
               bi.next_pc, bi.branch_taken, bi.taken_count);
    end
    do_exec(1'b1, 8'h20, 8'h80, 3'b000, 1'b0, 1'b0, 1'b1);
    checks++;
    if (bi.next_pc !== 8'h21 || bi.branch_taken !== 1'b0
        || bi.stack_underflow !== 1'b0) begin
      errors++;
      $display("FAIL ret_nostack pc=%h tk=%b unf=%b",
               bi.next_pc, bi.branch_taken,
               bi.stack_underflow);
    end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_branch_taken();
    test_branch_not_taken();
    test_hold();
    test_saturate();
    test_stack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
